// File: rtl/dsp_stream_driver.sv
// Purpose: sequences an external tap-delay filter one sample at a time and captures its result.
// Latency: accept at the edge ending cycle N gives m_valid high from cycle N+3; one sample per 4 cycles at best.
// Backpressure: the result is held stable until m_ready; s_ready stays low until the output has drained.
module dsp_stream_driver #(
    parameter logic [4:0] SHIFT_CODE = 5'b00001,
    parameter logic [4:0] IDLE_CODE  = 5'b00000,
    parameter int         TAPS       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        flush,
    output logic [4:0]  dsp_control,
    output logic [31:0] dsp_sample,
    input  logic [31:0] dsp_filtered,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_warm
);

    // Counter wide enough to hold TAPS itself (fill count saturates at TAPS).
    localparam int            CW         = $clog2(TAPS + 1);
    localparam logic [CW-1:0] TAPS_C     = CW'(TAPS);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(TAPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    state_t        state_q,      state_d;
    logic [CW-1:0] fill_cnt_q,   fill_cnt_d;
    logic [CW-1:0] flush_cnt_q,  flush_cnt_d;
    logic [31:0]   dsp_sample_q, dsp_sample_d;
    logic          m_valid_q,    m_valid_d;
    logic [31:0]   m_data_q,     m_data_d;
    logic          m_warm_q,     m_warm_d;

    // Next-state and output decode; every register holds unless its state says otherwise.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        dsp_sample_d = dsp_sample_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_warm_d     = m_warm_q;
        dsp_control  = IDLE_CODE;
        s_ready      = 1'b0;

        case (state_q)
            IDLE: begin
                // A flush request wins over a concurrent sample, which is refused.
                s_ready = !flush;
                if (flush) begin
                    dsp_sample_d = 32'd0;
                    flush_cnt_d  = '0;
                    state_d      = FLUSH;
                end else if (s_valid) begin
                    dsp_sample_d = s_data;
                    state_d      = SHIFT;
                end
            end

            SHIFT: begin
                // Single-cycle shift command; the window count saturates once full.
                dsp_control = SHIFT_CODE;
                if (fill_cnt_q != TAPS_C) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
                state_d = CAPTURE;
            end

            CAPTURE: begin
                // Filter output settles after the shift edge; sample it unmodified.
                m_data_d  = dsp_filtered;
                m_warm_d  = (fill_cnt_q == TAPS_C);
                m_valid_d = 1'b1;
                state_d   = HOLD;
            end

            HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            FLUSH: begin
                // Shift TAPS zeros through the window, then the window is empty again.
                dsp_control = SHIFT_CODE;
                fill_cnt_d  = '0;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that discards any in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            dsp_sample_q <= 32'd0;
            m_valid_q    <= 1'b0;
            m_data_q     <= 32'd0;
            m_warm_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            dsp_sample_q <= dsp_sample_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_warm_q     <= m_warm_d;
        end
    end

    assign dsp_sample = dsp_sample_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_warm     = m_warm_q;

endmodule
